bv_select: RTL

Downstream consumer of the bit-vector functional unit: takes each result vector and selects one set bit, either the lowest-index set bit or the next set bit in round-robin order from a held pointer. It emits the selected index, a found flag, and the input vector with the selected bit cleared, so a caller can loop the vector back for iterative dequeue. It is a fixed 2-cycle, valid-only streaming pipeline with no backpressure, matching the producer's output protocol.

---
 rtl/bv_select.sv | 108 ++++++++++
 1 files changed

// File: rtl/bv_select.sv
// Selects one set bit of a vector (lowest, or round-robin from rr_ptr) and
// returns its index, a found flag and the vector with that bit cleared.
module bv_select #(
  parameter int BIT_VEC_SIZE = 128,
  parameter int IDX_WIDTH    = $clog2(BIT_VEC_SIZE),
  parameter int CHUNK        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIT_VEC_SIZE-1:0] in_vec,
  input  logic                    valid_in,
  input  logic                    mode,
  input  logic                    ptr_load,
  input  logic [IDX_WIDTH-1:0]    ptr_value,
  output logic [IDX_WIDTH-1:0]    out_idx,
  output logic                    out_found,
  output logic [BIT_VEC_SIZE-1:0] out_vec,
  output logic                    valid_out,
  output logic [IDX_WIDTH-1:0]    rr_ptr
);

  localparam int NCHUNK = BIT_VEC_SIZE / CHUNK;

  // Two-level priority encode: first non-zero chunk from the summary, then
  // the first set bit inside that chunk.
  function automatic logic [IDX_WIDTH-1:0] pick_lowest(
    input logic [BIT_VEC_SIZE-1:0] v,
    input logic [NCHUNK-1:0]       s
  );
    logic [CHUNK-1:0] w;
    int ci;
    int bi;
    ci = 0;
    bi = 0;
    w  = v[CHUNK-1:0];
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (s[i]) begin
        ci = i;
        w  = v[i*CHUNK +: CHUNK];
      end
    end
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (w[j]) bi = j;
    end
    return IDX_WIDTH'(ci * CHUNK + bi);
  endfunction

  function automatic logic [NCHUNK-1:0] chunk_summary(
    input logic [BIT_VEC_SIZE-1:0] v
  );
    logic [NCHUNK-1:0] s;
    for (int i = 0; i < NCHUNK; i++) s[i] = |v[i*CHUNK +: CHUNK];
    return s;
  endfunction

  // ---- stage 1: capture vector, mode and pointer-independent summary ----
  logic [BIT_VEC_SIZE-1:0] vec_p1;
  logic [NCHUNK-1:0]       sum_p1;
  logic                    mode_p1;
  logic                    vld_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= valid_in;
    vec_p1  <= in_vec;
    sum_p1  <= chunk_summary(in_vec);
    mode_p1 <= mode;
  end

  // ---- stage 2: pointer-relative selection and result registers ----
  logic [BIT_VEC_SIZE-1:0] hi_vec;
  logic [NCHUNK-1:0]       hi_sum;
  logic                    found;
  logic [IDX_WIDTH-1:0]    sel_idx;
  logic [BIT_VEC_SIZE-1:0] sel_oh;

  always_comb begin
    hi_vec = vec_p1 & ({BIT_VEC_SIZE{1'b1}} << rr_ptr);
    hi_sum = chunk_summary(hi_vec);
    found  = |sum_p1;
    // Round-robin falls back to the global lowest bit when nothing sits at or above the pointer.
    if (mode_p1 && (|hi_sum)) sel_idx = pick_lowest(hi_vec, hi_sum);
    else                      sel_idx = pick_lowest(vec_p1, sum_p1);
    sel_oh = found ? (BIT_VEC_SIZE'(1) << sel_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      out_found <= 1'b0;
      out_idx   <= '0;
      out_vec   <= '0;
      rr_ptr    <= '0;
    end else begin
      valid_out <= vld_p1;
      if (vld_p1) begin
        out_found <= found;
        out_idx   <= sel_idx;
        out_vec   <= vec_p1 & ~sel_oh;
      end
      if (ptr_load)
        rr_ptr <= ptr_value;
      else if (vld_p1 && mode_p1 && found)
        rr_ptr <= sel_idx + 1'b1;
    end
  end

endmodule
